// File: rtl/vga_cell_mem_arbiter_if.sv
// Cell memory arbiter bus: timing line, scan-out read port, engine
// request/access port and the registered RAM port. MEM_W is ADDR_W for a
// single bank build and ADDR_W+1 when CELL_DBUF_EN is defined.
interface vga_cell_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int MEM_W  = ADDR_W
);
  logic [11:0]       vCount;
  logic              disp_re;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic              eng_req;
  logic              eng_done;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_we;
  logic              eng_wdata;
  logic              eng_grant;
  logic              eng_abort;
  logic [MEM_W-1:0]  mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              bank_sel;

  // The arbiter side: takes requests and timing, drives grant and RAM port.
  modport slave (
    input  vCount, disp_re, disp_addr, eng_req, eng_done,
           eng_addr, eng_we, eng_wdata,
    output disp_valid, eng_grant, eng_abort, mem_addr, mem_we,
           mem_wdata, bank_sel
  );

  // The requester side: timing counters, scan-out and update engine.
  modport master (
    output vCount, disp_re, disp_addr, eng_req, eng_done,
           eng_addr, eng_we, eng_wdata,
    input  disp_valid, eng_grant, eng_abort, mem_addr, mem_we,
           mem_wdata, bank_sel
  );
endinterface

// File: rtl/vga_cell_mem_arbiter.sv
// vga_cell_mem_arbiter: shares the single-port cell RAM between VGA
// scan-out (default owner) and the Game-of-Life update engine, which is
// granted the port only inside the vertical-blanking window. A pass that
// overruns the window is aborted.
// Optional feature macro: CELL_DBUF_EN (double-buffered cell memory; the
// engine writes the bank not being displayed and the banks swap after a
// completed pass).
module vga_cell_mem_arbiter #(
  parameter int VPIXEL      = 480,
  parameter int V_TOTAL     = 525,
  parameter int GUARD_LINES = 2,
  parameter int ADDR_W      = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_cell_mem_arbiter_if.slave bus
);

`ifdef CELL_DBUF_EN
  localparam int MEM_W = ADDR_W + 1;
`else
  localparam int MEM_W = ADDR_W;
`endif

  // Window bounds as line numbers; the window closes GUARD_LINES before the
  // frame wraps so a running pass is stopped before scan-out resumes.
  localparam logic [11:0] WIN_OPEN  = 12'(VPIXEL);
  localparam logic [11:0] WIN_CLOSE = 12'(V_TOTAL - GUARD_LINES);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t           state;
  logic             in_window;
  logic             eng_grant;
  logic             eng_abort;
  logic             bank_sel;
  logic             rd_stage;
  logic             disp_valid;
  logic [MEM_W-1:0] mem_addr;
  logic             mem_we;
  logic             mem_wdata;
  logic [MEM_W-1:0] eng_full_addr;
  logic [MEM_W-1:0] disp_full_addr;

  assign in_window = (bus.vCount >= WIN_OPEN) && (bus.vCount < WIN_CLOSE);

`ifdef CELL_DBUF_EN
  // Engine works on the hidden bank, scan-out reads the displayed one.
  assign eng_full_addr  = {~bank_sel, bus.eng_addr};
  assign disp_full_addr = { bank_sel, bus.disp_addr};
`else
  // One shared bank; bank select is meaningless and held low.
  assign eng_full_addr  = bus.eng_addr;
  assign disp_full_addr = bus.disp_addr;
  assign bank_sel       = 1'b0;
`endif

  // Grant FSM with registered grant/abort; a completed pass also swaps banks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      eng_grant <= 1'b0;
      eng_abort <= 1'b0;
`ifdef CELL_DBUF_EN
      bank_sel  <= 1'b0;
`endif
    end else begin
      eng_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.eng_req && in_window) begin
            state     <= GRANT;
            eng_grant <= 1'b1;
          end
        end
        GRANT: begin
          if (bus.eng_done) begin
            state     <= RELEASE;
            eng_grant <= 1'b0;
`ifdef CELL_DBUF_EN
            bank_sel  <= ~bank_sel;
`endif
          end else if (!in_window) begin
            state     <= RELEASE;
            eng_grant <= 1'b0;
            eng_abort <= 1'b1;
          end else if (!bus.eng_req) begin
            state     <= RELEASE;
            eng_grant <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          eng_grant <= 1'b0;
        end
      endcase
    end
  end

  // Registered RAM port mux; writes are only possible while the grant is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 1'b0;
    end else if (eng_grant) begin
      mem_addr  <= eng_full_addr;
      mem_we    <= bus.eng_we;
      mem_wdata <= bus.eng_wdata;
    end else begin
      mem_addr  <= disp_full_addr;
      mem_we    <= 1'b0;
      mem_wdata <= 1'b0;
    end
  end

  // Two-stage read tracker: address register, then RAM output cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_stage   <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      rd_stage   <= bus.disp_re & ~eng_grant;
      disp_valid <= rd_stage;
    end
  end

  assign bus.eng_grant  = eng_grant;
  assign bus.eng_abort  = eng_abort;
  assign bus.bank_sel   = bank_sel;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_we     = mem_we;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.disp_valid = disp_valid;

endmodule

// File: tb/tb_vga_cell_mem_arbiter.sv
// Directed testbench for vga_cell_mem_arbiter. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at the same point.
// Expectations follow the CELL_DBUF_EN macro when it is defined.
module tb_vga_cell_mem_arbiter;

`ifdef CELL_DBUF_EN
  localparam int TB_MEM_W = 14;
`else
  localparam int TB_MEM_W = 13;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic exp_bank;
  logic [TB_MEM_W-1:0] exp_addr;

  vga_cell_mem_arbiter_if #(.ADDR_W(13), .MEM_W(TB_MEM_W)) bus ();

  vga_cell_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Return all requester inputs to a quiet state.
  task automatic applyStimulus(input logic [11:0] line, input logic req);
    bus.vCount    = line;
    bus.eng_req   = req;
    bus.eng_done  = 1'b0;
    bus.eng_we    = 1'b0;
    bus.eng_wdata = 1'b0;
    bus.eng_addr  = '0;
    bus.disp_re   = 1'b0;
    bus.disp_addr = '0;
  endtask

  // Reset clears everything even with a pending request; grant waits for line 480.
  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(12'd100, 1'b1);
    tick; tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_grant: got %b want 0", bus.eng_grant); end
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_abort: got %b want 0", bus.eng_abort); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    vectors++; if (bus.mem_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata: got %b want 0", bus.mem_wdata); end
    vectors++; if (bus.disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_disp_valid: got %b want 0", bus.disp_valid); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("[TB] FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    vectors++; if (bus.bank_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bank_sel: got %b want 0", bus.bank_sel); end
    reset = 1'b0;
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL pending_100: got %b want 0", bus.eng_grant); end
    bus.vCount = 12'd479;
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL pending_479: got %b want 0", bus.eng_grant); end
    bus.vCount = 12'd480;
    tick;
    vectors++; if (bus.eng_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL grant_480: got %b want 1", bus.eng_grant); end
    // Reset while granted drops the grant without abort or swap.
    reset = 1'b1;
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_grant: got %b want 0", bus.eng_grant); end
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_abort: got %b want 0", bus.eng_abort); end
    vectors++; if (bus.bank_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_bank: got %b want 0", bus.bank_sel); end
    reset = 1'b0;
    exp_bank = 1'b0;
    applyStimulus(12'd10, 1'b0);
    tick; tick;
  endtask

  // Scan-out read during the visible region.
  task automatic test_display_read;
    applyStimulus(12'd10, 1'b0);
    bus.disp_re   = 1'b1;
    bus.disp_addr = 13'h055;
    tick;
`ifdef CELL_DBUF_EN
    exp_addr = {exp_bank, 13'h055};
`else
    exp_addr = 13'h055;
`endif
    vectors++; if (bus.mem_addr !== exp_addr) begin miscompares++; $display("[TB] FAIL rd_addr: got %h want %h", bus.mem_addr, exp_addr); end
    vectors++; if (bus.disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_valid_early: got %b want 0", bus.disp_valid); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_we1: got %b want 0", bus.mem_we); end
    bus.disp_re = 1'b0;
    tick;
    vectors++; if (bus.disp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_valid: got %b want 1", bus.disp_valid); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_we2: got %b want 0", bus.mem_we); end
    tick;
    vectors++; if (bus.disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_valid_drop: got %b want 0", bus.disp_valid); end
  endtask

  // Engine write pass finished with eng_done.
  task automatic test_engine_write;
    applyStimulus(12'd480, 1'b1);
    tick;
    vectors++; if (bus.eng_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_grant: got %b want 1", bus.eng_grant); end
    bus.eng_addr  = 13'h1FF;
    bus.eng_we    = 1'b1;
    bus.eng_wdata = 1'b1;
    tick;
`ifdef CELL_DBUF_EN
    exp_addr = {~exp_bank, 13'h1FF};
`else
    exp_addr = 13'h1FF;
`endif
    vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_we: got %b want 1", bus.mem_we); end
    vectors++; if (bus.mem_addr !== exp_addr) begin miscompares++; $display("[TB] FAIL wr_addr: got %h want %h", bus.mem_addr, exp_addr); end
    vectors++; if (bus.mem_wdata !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_wdata: got %b want 1", bus.mem_wdata); end
    bus.eng_we   = 1'b0;
    bus.vCount   = 12'd500;
    bus.eng_done = 1'b1;
    tick;
`ifdef CELL_DBUF_EN
    exp_bank = ~exp_bank;
`endif
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL done_grant: got %b want 0", bus.eng_grant); end
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL done_abort: got %b want 0", bus.eng_abort); end
    vectors++; if (bus.bank_sel !== exp_bank) begin miscompares++; $display("[TB] FAIL done_bank: got %b want %b", bus.bank_sel, exp_bank); end
    applyStimulus(12'd500, 1'b0);
    tick;
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL post_done_we: got %b want 0", bus.mem_we); end
    tick;
  endtask

  // Pass overruns the window and is aborted; no re-grant after the close.
  task automatic test_abort;
    applyStimulus(12'd480, 1'b1);
    tick;
    bus.vCount = 12'd522;
    tick;
    vectors++; if (bus.eng_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL ab_hold_522: got %b want 1", bus.eng_grant); end
    bus.vCount = 12'd523;
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL ab_grant: got %b want 0", bus.eng_grant); end
    vectors++; if (bus.eng_abort !== 1'b1) begin miscompares++; $display("[TB] FAIL ab_pulse: got %b want 1", bus.eng_abort); end
    tick;
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL ab_single: got %b want 0", bus.eng_abort); end
    vectors++; if (bus.bank_sel !== exp_bank) begin miscompares++; $display("[TB] FAIL ab_bank: got %b want %b", bus.bank_sel, exp_bank); end
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL ab_no_regrant: got %b want 0", bus.eng_grant); end
    bus.vCount = 12'd524;
    tick;
    bus.vCount = 12'd0;
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_closed: got %b want 0", bus.eng_grant); end
    applyStimulus(12'd10, 1'b0);
    tick;
  endtask

  // eng_done coinciding with the window close wins over the abort.
  task automatic test_done_at_close;
    applyStimulus(12'd480, 1'b1);
    tick;
    bus.vCount = 12'd522;
    tick;
    bus.vCount   = 12'd523;
    bus.eng_done = 1'b1;
    tick;
`ifdef CELL_DBUF_EN
    exp_bank = ~exp_bank;
`endif
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL dc_abort: got %b want 0", bus.eng_abort); end
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL dc_grant: got %b want 0", bus.eng_grant); end
    vectors++; if (bus.bank_sel !== exp_bank) begin miscompares++; $display("[TB] FAIL dc_bank: got %b want %b", bus.bank_sel, exp_bank); end
    applyStimulus(12'd10, 1'b0);
    tick;
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL dc_abort_late: got %b want 0", bus.eng_abort); end
    tick;
  endtask

  // Scan-out reads are ignored while the engine owns the port.
  task automatic test_disp_while_granted;
    applyStimulus(12'd480, 1'b1);
    tick;
    bus.disp_re   = 1'b1;
    bus.disp_addr = 13'h055;
    bus.eng_addr  = 13'h0AA;
    tick;
`ifdef CELL_DBUF_EN
    exp_addr = {~exp_bank, 13'h0AA};
`else
    exp_addr = 13'h0AA;
`endif
    vectors++; if (bus.mem_addr !== exp_addr) begin miscompares++; $display("[TB] FAIL gr_addr: got %h want %h", bus.mem_addr, exp_addr); end
    vectors++; if (bus.disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL gr_valid1: got %b want 0", bus.disp_valid); end
    tick;
    vectors++; if (bus.disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL gr_valid2: got %b want 0", bus.disp_valid); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL gr_we: got %b want 0", bus.mem_we); end
    // Dropping the request releases without abort or swap.
    bus.disp_re = 1'b0;
    bus.eng_req = 1'b0;
    tick;
    vectors++; if (bus.eng_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_grant: got %b want 0", bus.eng_grant); end
    vectors++; if (bus.eng_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_abort: got %b want 0", bus.eng_abort); end
    vectors++; if (bus.bank_sel !== exp_bank) begin miscompares++; $display("[TB] FAIL drop_bank: got %b want %b", bus.bank_sel, exp_bank); end
    tick;
    vectors++; if (bus.disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL gr_valid3: got %b want 0", bus.disp_valid); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_bank    = 1'b0;
    exp_addr    = '0;
    reset       = 1'b1;
    applyStimulus(12'd100, 1'b1);
    test_reset;
    test_display_read;
    test_engine_write;
    test_abort;
    test_done_at_close;
    test_disp_while_granted;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
